// File: rtl/imem_boot_loader.sv
// imem_boot_loader: receives a length-prefixed byte stream, packs it into 32-bit
// little-endian words, writes them to consecutive instruction memory addresses,
// then releases the core and hands the memory address port to the fetch path.
// Optional feature macro: IMEM_LOAD_CHECKSUM_EN (8-bit XOR checksum byte after payload).
module imem_boot_loader #(
  parameter int DEPTH = 256,
  parameter int WIDTH = 32,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic             rx_ready,
  input  logic [AW-1:0]    pc_addr,
  output logic             mem_we,
  output logic [AW-1:0]    mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             core_hold,
  output logic             busy,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {IDLE, HDR0, HDR1, LOAD, CHECK, FLUSH, RUN, ERROR} state_t;

  state_t        state, nxt;
  logic [7:0]    len_lo;
  logic [15:0]   len;
  logic [1:0]    bcnt;
  logic [AW-1:0] wcnt;
  logic [AW-1:0] load_addr;
  logic [23:0]   wbuf;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  logic        acc, start_ok, last_word, hdr_bad;
  logic [15:0] len_new;

  // rx_ready is a pure decode of the state register, so no rx_valid->rx_ready path
  assign rx_ready  = (state == HDR0) || (state == HDR1) || (state == LOAD) || (state == CHECK);
  assign busy      = rx_ready || (state == FLUSH);
  assign done      = (state == RUN);
  assign error     = (state == ERROR);
  assign core_hold = (state != RUN);
  assign mem_addr  = done ? pc_addr : load_addr;

  assign acc       = rx_valid && rx_ready;
  assign start_ok  = start && ((state == IDLE) || (state == RUN) || (state == ERROR));
  assign len_new   = {rx_data, len_lo};
  assign hdr_bad   = (len_new == 16'd0) || (32'(len_new) > DEPTH);
  assign last_word = (16'(wcnt) == (len - 16'd1));

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  // next-state decode
  always_comb begin
    nxt = state;
    case (state)
      IDLE, RUN, ERROR: if (start) nxt = HDR0;
      HDR0: if (acc) nxt = HDR1;
      HDR1: if (acc) nxt = hdr_bad ? ERROR : LOAD;
      LOAD: if (acc && bcnt == 2'd3 && last_word) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
        nxt = CHECK;
`else
        nxt = FLUSH;
`endif
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      CHECK: if (acc) nxt = (rx_data == csum) ? RUN : ERROR;
`endif
      FLUSH: nxt = RUN;
      default: nxt = IDLE;
    endcase
  end

  // header capture, word assembly and single-cycle write strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      load_addr <= '0;
      bcnt      <= '0;
      wcnt      <= '0;
      len_lo    <= '0;
      len       <= '0;
      wbuf      <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      mem_we <= 1'b0;
      if (start_ok) begin
        bcnt <= '0;
        wcnt <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
        csum <= '0;
`endif
      end else if (acc) begin
        case (state)
          HDR0: len_lo <= rx_data;
          HDR1: len    <= len_new;
          LOAD: begin
            bcnt <= bcnt + 2'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum <= csum ^ rx_data;
`endif
            case (bcnt)
              2'd0: wbuf[7:0]   <= rx_data;
              2'd1: wbuf[15:8]  <= rx_data;
              2'd2: wbuf[23:16] <= rx_data;
              default: begin
                mem_wdata <= {rx_data, wbuf};
                load_addr <= wcnt;
                mem_we    <= 1'b1;
                wcnt      <= wcnt + AW'(1);
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: randomized byte streams and gaps,
// expected memory writes derived from the payload bytes by a queue-based model.
module tb_imem_boot_loader;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst, start, rx_valid, rx_ready;
  logic [7:0]    rx_data;
  logic [AW-1:0] pc_addr, mem_addr;
  logic          mem_we, core_hold, busy, done, error;
  logic [31:0]   mem_wdata;

  int total = 0, passed = 0, timeouts = 0;
  logic [7:0]     payload[$];
  logic [AW+31:0] wq[$];

  always #5 clk = ~clk;

  imem_boot_loader dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .pc_addr(pc_addr), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .core_hold(core_hold), .busy(busy), .done(done), .error(error)
  );

  // record every memory write seen on the port
  always @(posedge clk) begin
    #1;
    if (mem_we) wq.push_back({mem_addr, mem_wdata});
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // model: word k is bytes 4k..4k+3 of the payload, little-endian
  function automatic logic [31:0] exp_word(int k);
    return {payload[4*k+3], payload[4*k+2], payload[4*k+1], payload[4*k]};
  endfunction

  function automatic logic [7:0] model_csum();
    logic [7:0] x = 8'h00;
    foreach (payload[i]) x ^= payload[i];
    return x;
  endfunction

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) timeouts++;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b, input int maxgap);
    rx_data = 8'($urandom);
    repeat ($urandom_range(0, maxgap)) @(negedge clk);
    send_byte(b);
  endtask

  task automatic load_payload(input int n, input int maxgap);
    pulse_start();
    send_gap(8'(n), maxgap);
    send_gap(8'(n >> 8), maxgap);
    foreach (payload[i]) send_gap(payload[i], maxgap);
  endtask

  task automatic finish_load(input int maxgap);
`ifdef IMEM_LOAD_CHECKSUM_EN
    send_gap(model_csum(), maxgap);
`else
    @(negedge clk);
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; pc_addr = '0;
    repeat (2) @(negedge clk);
    total++;
    if ({core_hold, rx_ready, mem_we, done, error, busy} !== 6'b100000)
      $display("FAIL reset_flags: got %b want 100000", {core_hold, rx_ready, mem_we, done, error, busy});
    else passed++;
    total++;
    if (mem_wdata !== 32'h0 || mem_addr !== '0)
      $display("FAIL reset_data: got wdata %h addr %h want 0 0", mem_wdata, mem_addr);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic_load();
    wq.delete();
    payload = '{8'h93, 8'h00, 8'h20, 8'h03, 8'h13, 8'h01, 8'h60, 8'h03};
    load_payload(2, 0);
    // cycle after the last byte: final write on the port, core still held
    total++;
    if (!(mem_we === 1'b1 && mem_addr === 8'd1 && mem_wdata === 32'h03600113 && core_hold === 1'b1 && busy === 1'b1))
      $display("FAIL basic_last_write: got we %b addr %h data %h hold %b busy %b want 1 01 03600113 1 1",
               mem_we, mem_addr, mem_wdata, core_hold, busy);
    else passed++;
    finish_load(0);
    total++;
    if ({core_hold, done, mem_we, rx_ready, busy} !== 5'b01000)
      $display("FAIL basic_release: got hold/done/we/rdy/busy %b want 01000", {core_hold, done, mem_we, rx_ready, busy});
    else passed++;
    total++;
    if (wq.size() !== 2 || wq[0] !== {8'd0, 32'h03200093} || wq[1] !== {8'd1, 32'h03600113})
      $display("FAIL basic_writes: got n=%0d w0 %h w1 %h want 2 0003200093 0103600113", wq.size(), wq[0], wq[1]);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      pc_addr = AW'($urandom);
      #1;
      total++;
      if (mem_addr !== pc_addr) $display("FAIL run_pc_addr: got %h want %h", mem_addr, pc_addr);
      else passed++;
    end
    @(negedge clk);
  endtask

  task automatic test_header_errors();
    logic [15:0] hdrs[2];
    hdrs[0] = 16'h0000;
    hdrs[1] = 16'h0101;
    for (int h = 0; h < 2; h++) begin
      wq.delete();
      pulse_start();
      send_byte(hdrs[h][7:0]);
      send_byte(hdrs[h][15:8]);
      repeat (3) @(negedge clk);
      total++;
      if ({error, core_hold, rx_ready, busy, done} !== 5'b11000)
        $display("FAIL hdr_err_%0h: got err/hold/rdy/busy/done %b want 11000", hdrs[h], {error, core_hold, rx_ready, busy, done});
      else passed++;
      total++;
      if (wq.size() !== 0) $display("FAIL hdr_err_writes: got %0d want 0", wq.size());
      else passed++;
    end
  endtask

  task automatic test_random_loads(input int iters, input int maxgap, input int maxn);
    for (int it = 0; it < iters; it++) begin
      int n = $urandom_range(1, maxn);
      int bad = 0;
      wq.delete();
      payload.delete();
      for (int i = 0; i < 4 * n; i++) payload.push_back(8'($urandom));
      load_payload(n, maxgap);
      finish_load(maxgap);
      for (int k = 0; k < n; k++)
        if (wq[k] !== {AW'(k), exp_word(k)}) bad++;
      total++;
      if (wq.size() !== n || bad !== 0)
        $display("FAIL rand_load_writes n=%0d: got %0d writes, %0d wrong, w0 %h want w0 %h",
                 n, wq.size(), bad, wq[0], {8'd0, exp_word(0)});
      else passed++;
      total++;
      if ({done, core_hold, error} !== 3'b100)
        $display("FAIL rand_load_final n=%0d: got done/hold/err %b want 100", n, {done, core_hold, error});
      else passed++;
    end
  endtask

  task automatic test_start_handling();
    wq.delete();
    payload = '{8'h93, 8'h00, 8'h20, 8'h03, 8'h13, 8'h01, 8'h60, 8'h03};
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 5; i++) send_byte(payload[i]);
    pulse_start();
    for (int i = 5; i < 8; i++) send_byte(payload[i]);
    finish_load(0);
    total++;
    if (wq.size() !== 2 || wq[0] !== {8'd0, 32'h03200093} || wq[1] !== {8'd1, 32'h03600113} || done !== 1'b1)
      $display("FAIL start_in_load: got n=%0d w0 %h w1 %h done %b want 2 0003200093 0103600113 1",
               wq.size(), wq[0], wq[1], done);
    else passed++;
    pulse_start();
    total++;
    if ({core_hold, busy, done, rx_ready} !== 4'b1101)
      $display("FAIL start_in_run: got hold/busy/done/rdy %b want 1101", {core_hold, busy, done, rx_ready});
    else passed++;
    wq.delete();
    payload = '{8'h67, 8'h80, 8'h00, 8'h00};
    send_byte(8'h01);
    send_byte(8'h00);
    foreach (payload[i]) send_byte(payload[i]);
    finish_load(0);
    total++;
    if (wq.size() !== 1 || wq[0] !== {8'd0, 32'h00008067} || done !== 1'b1)
      $display("FAIL reload: got n=%0d w0 %h done %b want 1 0000008067 1", wq.size(), wq[0], done);
    else passed++;
  endtask

  task automatic test_reset_mid_load();
    wq.delete();
    payload = '{8'h93, 8'h00, 8'h20, 8'h03, 8'h13, 8'h01, 8'h60, 8'h03};
    pulse_start();
    send_byte(8'h02);
    send_byte(8'h00);
    for (int i = 0; i < 5; i++) send_byte(payload[i]);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({busy, core_hold, rx_ready, mem_we, done, error} !== 6'b010000 || mem_addr !== '0 || mem_wdata !== 32'h0)
      $display("FAIL rst_mid_load: got busy/hold/rdy/we/done/err %b addr %h data %h want 010000 00 00000000",
               {busy, core_hold, rx_ready, mem_we, done, error}, mem_addr, mem_wdata);
    else passed++;
    total++;
    if (wq.size() !== 1 || wq[0] !== {8'd0, 32'h03200093})
      $display("FAIL rst_mid_writes: got n=%0d w0 %h want 1 0003200093", wq.size(), wq[0]);
    else passed++;
    // reset and start together: reset wins
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    total++;
    if ({busy, core_hold, rx_ready} !== 3'b010)
      $display("FAIL rst_beats_start: got busy/hold/rdy %b want 010", {busy, core_hold, rx_ready});
    else passed++;
  endtask

`ifdef IMEM_LOAD_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] cks[2];
    cks[0] = 8'hE7;
    cks[1] = 8'hE6;
    for (int c = 0; c < 2; c++) begin
      wq.delete();
      payload = '{8'h67, 8'h80, 8'h00, 8'h00};
      load_payload(1, 0);
      total++;
      if (!(mem_we === 1'b1 && rx_ready === 1'b1 && core_hold === 1'b1))
        $display("FAIL csum_check_state: got we/rdy/hold %b want 111", {mem_we, rx_ready, core_hold});
      else passed++;
      send_byte(cks[c]);
      total++;
      if ({done, error, core_hold} !== ((cks[c] == model_csum()) ? 3'b100 : 3'b011))
        $display("FAIL csum_%0h: got done/err/hold %b", cks[c], {done, error, core_hold});
      else passed++;
    end
  endtask
`endif

  task automatic test_timeouts();
    total++;
    if (timeouts !== 0) $display("FAIL handshake_timeouts: got %0d want 0", timeouts);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_header_errors();
    test_random_loads(1, 5, 2);
    test_random_loads(6, 3, 8);
    test_start_handling();
    test_reset_mid_load();
    test_random_loads(2, 0, 8);
    test_random_loads(1, 0, 256);
`ifdef IMEM_LOAD_CHECKSUM_EN
    test_checksum();
`endif
    test_timeouts();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/imem_boot_loader.md
# imem_boot_loader

Boot-time program loader and port controller for the single-port instruction memory. It holds the core in reset and receives a length-prefixed byte stream, for example from a UART receiver. It assembles the bytes into 32-bit little-endian words and writes them to consecutive word addresses. Once the load completes it releases the core and hands the memory address port to the fetch path (`pc_addr`).

## Interface
- `DEPTH`, 256, instruction memory depth in words; `AW = $clog2(DEPTH)`.
- `WIDTH`, 32, instruction word width; fixed at 32.
- `clk  in  1  clock`; one clock; all state on the rising edge.
- `rst  in  1`: reset is synchronous and active-high.
- `start  in  1`: single-cycle request to begin a load.
- `rx_data  in  8`: stream byte.
- `rx_valid  in  1`: `rx_data` is valid.
- `rx_ready  out  1`: loader accepts a byte; transfer occurs when `rx_valid && rx_ready`.
- `pc_addr  in  AW`: word address from the core fetch stage.
- `mem_we  out  1`: instruction memory write enable.
- `mem_addr  out  AW`: memory word address.
- `mem_wdata  out  32`: memory write data.
- `core_hold  out  1`: holds the core in reset while high.
- `busy  out  1`: high when in HDR0, HDR1, LOAD, CHECK or FLUSH.
- `done  out  1`: high in RUN.
- `error  out  1`: high in ERROR.

## Operation
- **States:** IDLE, HDR0, HDR1, LOAD, CHECK, FLUSH, RUN, ERROR.
- **Reset values:** state = IDLE; `core_hold` = 1; `rx_ready`, `mem_we`, `done`, `error`, `busy` = 0; `mem_wdata` = 0; load address = 0; byte counter = 0.
- **Start:**
  - Accepted only in IDLE, RUN or ERROR.
  - Effect: go to HDR0, clear word and byte counters, clear `error`, set `core_hold` = 1.
  - `start` in any other state is ignored.
- **Header:**
  - HDR0 accepts the length low byte; HDR1 accepts the high byte, giving N in words.
  - At the HDR1 acceptance edge: if N == 0 or N > DEPTH, go to ERROR; otherwise go to LOAD.
- **LOAD:**
  - Accepted bytes fill the word LSB first; the byte index wraps 0..3.
  - The edge accepting byte 3 of word k registers `mem_wdata` = the assembled word, the load address = k, and `mem_we` = 1 for exactly one cycle.
  - If k == N−1, the next state is FLUSH, or CHECK when `IMEM_LOAD_CHECKSUM_EN` is defined.
- **FLUSH:** one cycle in which the final write completes; `rx_ready` = 0; then go to RUN.
- **RUN:**
  - `core_hold` = 0, `rx_ready` = 0, `mem_we` = 0.
  - `mem_addr` = `pc_addr`, combinationally.
  - `mem_addr` shows the registered load address in every other state.
- **ERROR:** `core_hold` = 1, `rx_ready` = 0. The loader stays here until `start` or `rst`; a partial image may remain in memory.
- **`rx_ready`:** 1 in HDR0, HDR1, LOAD and CHECK; 0 in all other states.

## Timing
- The handshake is fully registered; there is no combinational path from `rx_valid` to `rx_ready`.
- `rx_valid` may drop for any number of cycles mid-word; the loader holds its state meanwhile.
- Write latency: `mem_we` is asserted in the cycle after byte 3 of a word is accepted.
- Back-to-back words at one byte per cycle produce a `mem_we` pulse every 4 cycles.
- Release latency (no checksum): `core_hold` falls 2 cycles after the last byte is accepted (LOAD → FLUSH → RUN).
- `rst` mid-load: next cycle is IDLE with reset values and `core_hold` = 1. Memory contents are not cleared.
- `start` and `rst` in the same cycle: `rst` wins.

## Configuration
- **`IMEM_LOAD_CHECKSUM_EN` defined:**
  - An 8-bit XOR of all payload bytes is accumulated; it is cleared on `start`.
  - After the last word the loader enters CHECK and accepts one checksum byte.
  - Match: go to RUN at that edge. Mismatch: go to ERROR.
  - The final `mem_we` occurs during the first CHECK cycle.
  - The FLUSH state is not used.
- **Not defined:** no CHECK state and no checksum byte; LOAD → FLUSH → RUN.

## Test plan
- **Basic load:** `start`, then header `02 00`, then bytes `93 00 20 03 13 01 60 03`, one per cycle. Required: `mem_we` pulses at addr 0 with data `0x03200093` and at addr 1 with data `0x03600113`; `core_hold` falls 2 cycles after the last byte; `done` = 1; `mem_addr` then tracks `pc_addr`.
- **Header errors:** header `00 00`, and separately header `01 01` (N = 257, DEPTH = 256). Required: ERROR, `error` = 1, `core_hold` = 1, `rx_ready` = 0, no `mem_we`.
- **Gapped stream:** repeat the basic load with 0–5 random idle cycles between bytes. Required: identical writes and final state.
- **Start handling:** `start` pulsed during LOAD has no effect and the load finishes normally. `start` in RUN raises `core_hold` next cycle, re-enters HDR0 and reloads 1 word (`0x00008067` at addr 0).
- **Reset mid-load:** `rst` after 5 payload bytes. Required: IDLE next cycle; only word 0 was written; `rx_ready` = 0; `core_hold` = 1.
- **Checksum (with `IMEM_LOAD_CHECKSUM_EN`):**
  - 1-word load of `0x00008067` followed by checksum byte `0xE7` gives RUN.
  - The same load followed by `0xE6` gives ERROR.
